fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the 5-stage pipelined CPU: owns the program counter, drives the instruction-memory address, and registers the fetched instruction and its PC into the IF/ID pipeline register consumed by decode/register-fetch. It accepts a stall from the hazard logic and a PC redirect from branch resolution. It also freezes fetch on a HALT encoding so simulations terminate cleanly.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset
- HALT_OP, 32'hD440_0000, instruction word that places the stage in HALT
- clk  in  1  sole clock, rising-edge
- reset  in  1  synchronous, active-high
- imem_addr  out  64  current PC, combinational from PC register
- imem_instr  in  32  instruction at imem_addr, valid in the same cycle (combinational read)
- stall  in  1  hold PC and IF/ID contents this cycle
- redirect_valid  in  1  replace PC with redirect_target and flush IF/ID
- redirect_target  in  64  branch/jump target byte address
- id_instr  out  32  registered instruction to decode
- id_pc  out  64  registered PC of id_instr (used for PC-relative branch targets)
- id_valid  out  1  id_instr is a real instruction (0 = bubble)
- halted  out  1  stage is in HALT

## Operation
- States: FETCH, STALL, HALT. Per rising edge, priority: reset > redirect_valid > stall > state action.
- reset: pc<=RESET_PC; id_instr<=0; id_pc<=0; id_valid<=0; state<=FETCH; halted=0.
- redirect_valid=1 (any state, stall ignored): pc<={redirect_target[63:2],2'b00}; id_valid<=0; id_instr, id_pc hold; state<=FETCH.
- stall=1 in FETCH or STALL: pc, id_* hold; state<=STALL. stall=1 in HALT: id_* hold, state stays HALT.
- FETCH/STALL with stall=0: id_instr<=imem_instr; id_pc<=pc; id_valid<=1. If imem_instr==HALT_OP: pc holds, state<=HALT; else pc<=pc+4, state<=FETCH.
- HALT with stall=0: id_valid<=0; pc holds; exits only via redirect or reset.
- pc+4 is modulo 2^64: 64'hFFFF_FFFF_FFFF_FFFC wraps to 0, no flag.
- Redirect target low two bits are discarded; no misalignment fault.
- halted = (state==HALT), combinational from state register.

## Timing
- Fetch latency 1 cycle: PC valid at imem_addr in cycle n, instruction appears on id_instr/id_valid after edge n.
- First instruction after reset deassertion: imem_addr=RESET_PC in cycle 0, id_valid=1 after edge 0.
- Redirect at edge n: id_valid=0 for cycle n+1 (one bubble), target instruction in ID after edge n+1.
- Stall asserted over k edges: exactly k edges of no PC/IF/ID change; no instruction lost or duplicated.
- Reset mid-stall, mid-halt or coincident with redirect: reset wins, all outputs to reset values at that edge.
- HALT instruction itself is delivered to ID with id_valid=1; all later cycles are bubbles.

## Structure
- Shared package cpu_pkg: INSTR_W=32, ADDR_W=64, HALT_OP default, fetch_state_t enum {FETCH, STALL, HALT}.
- One sub-module fetch_pc_next: combinational next-PC select (reset / redirect-aligned / hold / pc+4) using the codebase's 64-bit ripple adder for pc+4.
- PC and IF/ID registers plus state register live in fetch_stage; no other state.

## Test plan
- Reset then free-run with memory words 0x8B020020.. at 0,4,8 -> id_pc 0,4,8 on successive edges, id_valid=1 from edge 0.
- Stall held 3 cycles at pc=8 -> imem_addr=8, id_pc=4 unchanged for 3 edges; id_pc=8 after release, no skip.
- redirect_valid with target 0x103 while stall=1 -> pc=0x100 next edge, id_valid=0 one cycle, then id_pc=0x100.
- HALT_OP at address 0x10 -> id_instr=HALT_OP, id_valid=1 once, then id_valid=0, halted=1, imem_addr stays 0x10 for 20 cycles.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch at address 0 (wrap).
- reset asserted same edge as redirect while halted -> pc=RESET_PC, id_valid=0, halted=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the pipelined CPU: datapath widths, the HALT
// encoding, fetch-stage states and the ripple-carry adder used for address math.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [INSTR_W-1:0] HALT_OP_DEFAULT = 32'hD440_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;

  // Bit-serial carry chain; the carry out of the MSB is dropped, so sums wrap.
  function automatic logic [ADDR_W-1:0] ripple_add(input logic [ADDR_W-1:0] a,
                                                    input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] sum;
    logic              carry;
    carry = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    return sum;
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Next-PC select for the fetch stage: reset vector, word-aligned redirect
// target, hold, or sequential pc+4, in that priority.
module fetch_pc_next
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              reset,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  input  logic              hold,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  logic [ADDR_W-1:0] pc_plus4;

  assign pc_plus4 = ripple_add(pc, ADDR_W'(4));

  // NOTE: pc_next is given a value on every path so no latch is inferred.
  always_comb begin
    pc_next = pc_plus4;
    if (reset) begin
      pc_next = RESET_PC;
    end else if (redirect_valid) begin
      // Low two bits are dropped silently; misaligned targets are not faulted.
      pc_next = redirect_target & ~ADDR_W'(3);
    end else if (hold) begin
      pc_next = pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and fills the IF/ID register; honours stall, redirect and a HALT freeze.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC = 64'h0,
  parameter logic [INSTR_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               stall,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic [INSTR_W-1:0] id_instr,
  output logic [ADDR_W-1:0]  id_pc,
  output logic               id_valid,
  output logic               halted
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_next;
  logic              is_halt_op;
  logic              pc_hold;

  assign is_halt_op = (imem_instr == HALT_OP);
  // The PC freezes on a stall, while halted, and on the HALT word itself.
  assign pc_hold    = stall || (state == HALT) || is_halt_op;

  fetch_pc_next #(
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .hold            (pc_hold),
    .pc              (pc),
    .pc_next         (pc_next)
  );

  assign imem_addr = pc;
  assign halted    = (state == HALT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    pc <= pc_next;
    if (reset) begin
      id_instr <= '0;
      id_pc    <= '0;
      id_valid <= 1'b0;
      state    <= FETCH;
    end else if (redirect_valid) begin
      id_valid <= 1'b0;
      state    <= FETCH;
    end else if (stall) begin
      if (state != HALT) state <= STALL;
    end else if (state == HALT) begin
      id_valid <= 1'b0;
    end else begin
      id_instr <= imem_instr;
      id_pc    <= pc;
      id_valid <= 1'b1;
      state    <= is_halt_op ? HALT : FETCH;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the main flow plus
// hand-written sequences for halt hold, halt exit and reset corner cases.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [31:0] HOP     = 32'hD440_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;

  logic [63:0] imem_addr, w_imem_addr;
  logic [31:0] imem_instr, w_imem_instr;
  logic [31:0] id_instr, w_id_instr;
  logic [63:0] id_pc, w_id_pc;
  logic        id_valid, w_id_valid, halted, w_halted;

  logic [31:0] mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [63:0] addr);
    if (addr[1:0] == 2'b00 && (addr[63:10] == '0 || addr[63:10] == '1))
      return mem[addr[9:2]];
    return 32'hDEAD_BEEF;
  endfunction

  assign imem_instr   = mem_read(imem_addr);
  assign w_imem_instr = mem_read(w_imem_addr);

  fetch_stage #(.RESET_PC(64'h0), .HALT_OP(HOP)) dut (
    .clk (clk), .reset (reset), .imem_addr (imem_addr), .imem_instr (imem_instr),
    .stall (stall), .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .id_instr (id_instr), .id_pc (id_pc), .id_valid (id_valid), .halted (halted)
  );

  fetch_stage #(.RESET_PC(WRAP_PC), .HALT_OP(HOP)) dut_w (
    .clk (clk), .reset (reset), .imem_addr (w_imem_addr), .imem_instr (w_imem_instr),
    .stall (stall), .redirect_valid (redirect_valid), .redirect_target (redirect_target),
    .id_instr (w_id_instr), .id_pc (w_id_pc), .id_valid (w_id_valid), .halted (w_halted)
  );

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] w(input int i);
    return 32'h8B02_0020 + 32'(i);
  endfunction

  // Apply inputs, clock one edge, sample 1 time unit later.
  task automatic step(input logic rst, input logic stl, input logic rv, input logic [63:0] tgt);
    reset = rst; stall = stl; redirect_valid = rv; redirect_target = tgt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_main(input string name, input logic [63:0] e_addr, input logic [31:0] e_instr,
                            input logic [63:0] e_pc, input logic e_valid, input logic e_halted);
    check(name, {64'(imem_addr), 32'(id_instr), 64'(id_pc), 30'h0, id_valid, halted},
          {e_addr, e_instr, e_pc, 30'h0, e_valid, e_halted});
  endtask

  typedef struct {
    string       name;
    logic        rst, stl, rv;
    logic [63:0] tgt;
    logic [63:0] e_addr;
    logic [31:0] e_instr;
    logic [63:0] e_pc;
    logic        e_valid, e_halted;
    logic        chk_w;
    logic [63:0] e_waddr, e_wpc;
  } vec_t;

  vec_t vecs [16];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = w(i);
    mem[4] = HOP;

    //          name          rst  stl  rv   tgt      addr     instr   id_pc    vld  hlt  chkw waddr    wpc
    vecs[0]  = '{"reset",      1'b1,1'b0,1'b0,64'h0,   64'h0,   32'h0,  64'h0,   1'b0,1'b0,1'b1,WRAP_PC, 64'h0};
    vecs[1]  = '{"fetch0",     1'b0,1'b0,1'b0,64'h0,   64'h4,   w(0),   64'h0,   1'b1,1'b0,1'b1,64'h0,   WRAP_PC};
    vecs[2]  = '{"fetch4",     1'b0,1'b0,1'b0,64'h0,   64'h8,   w(1),   64'h4,   1'b1,1'b0,1'b1,64'h4,   64'h0};
    vecs[3]  = '{"stall1",     1'b0,1'b1,1'b0,64'h0,   64'h8,   w(1),   64'h4,   1'b1,1'b0,1'b0,64'h0,   64'h0};
    vecs[4]  = '{"stall2",     1'b0,1'b1,1'b0,64'h0,   64'h8,   w(1),   64'h4,   1'b1,1'b0,1'b0,64'h0,   64'h0};
    vecs[5]  = '{"stall3",     1'b0,1'b1,1'b0,64'h0,   64'h8,   w(1),   64'h4,   1'b1,1'b0,1'b0,64'h0,   64'h0};
    vecs[6]  = '{"unstall",    1'b0,1'b0,1'b0,64'h0,   64'hC,   w(2),   64'h8,   1'b1,1'b0,1'b0,64'h0,   64'h0};
    vecs[7]  = '{"redir_stl",  1'b0,1'b1,1'b1,64'h103, 64'h100, w(2),   64'h8,   1'b0,1'b0,1'b0,64'h0,   64'h0};
    vecs[8]  = '{"redir_tgt",  1'b0,1'b0,1'b0,64'h0,   64'h104, w(64),  64'h100, 1'b1,1'b0,1'b0,64'h0,   64'h0};
    vecs[9]  = '{"redir_mis",  1'b0,1'b0,1'b1,64'hE,   64'hC,   w(64),  64'h100, 1'b0,1'b0,1'b0,64'h0,   64'h0};
    vecs[10] = '{"fetchC",     1'b0,1'b0,1'b0,64'h0,   64'h10,  w(3),   64'hC,   1'b1,1'b0,1'b0,64'h0,   64'h0};
    vecs[11] = '{"halt_deliv", 1'b0,1'b0,1'b0,64'h0,   64'h10,  HOP,    64'h10,  1'b1,1'b1,1'b0,64'h0,   64'h0};
    vecs[12] = '{"halt_bubble",1'b0,1'b0,1'b0,64'h0,   64'h10,  HOP,    64'h10,  1'b0,1'b1,1'b0,64'h0,   64'h0};
    vecs[13] = '{"halt_stall", 1'b0,1'b1,1'b0,64'h0,   64'h10,  HOP,    64'h10,  1'b0,1'b1,1'b0,64'h0,   64'h0};
    vecs[14] = '{"halt_stl2",  1'b0,1'b1,1'b0,64'h0,   64'h10,  HOP,    64'h10,  1'b0,1'b1,1'b0,64'h0,   64'h0};
    vecs[15] = '{"halt_idle",  1'b0,1'b0,1'b0,64'h0,   64'h10,  HOP,    64'h10,  1'b0,1'b1,1'b0,64'h0,   64'h0};

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].stl, vecs[i].rv, vecs[i].tgt);
      check_main(vecs[i].name, vecs[i].e_addr, vecs[i].e_instr, vecs[i].e_pc,
                 vecs[i].e_valid, vecs[i].e_halted);
      if (vecs[i].chk_w)
        check({vecs[i].name, "_wrap"}, {64'(w_imem_addr), 64'(w_id_pc), 64'h0},
              {vecs[i].e_waddr, vecs[i].e_wpc, 64'h0});
    end

    // Halt persists: address frozen, only bubbles, for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0, 64'h0);
      check_main($sformatf("halt_hold%0d", i), 64'h10, HOP, 64'h10, 1'b0, 1'b1);
    end

    // Redirect is the only way out of HALT.
    step(1'b0, 1'b0, 1'b1, 64'h20);
    check_main("halt_exit", 64'h20, HOP, 64'h10, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check_main("post_exit", 64'h24, w(8), 64'h20, 1'b1, 1'b0);

    // Re-enter HALT, then reset coincident with redirect.
    step(1'b0, 1'b0, 1'b1, 64'h10);
    check_main("re_redir", 64'h10, w(8), 64'h20, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check_main("re_halt", 64'h10, HOP, 64'h10, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 64'h40);
    check_main("rst_redir", 64'h0, 32'h0, 64'h0, 1'b0, 1'b0);

    // Stall straight out of reset, reset mid-stall, then release.
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check_main("rst_stall", 64'h0, 32'h0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check_main("stall_rel", 64'h4, w(0), 64'h0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 64'h0);
    check_main("stall_b", 64'h4, w(0), 64'h0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 64'h0);
    check_main("rst_in_stall", 64'h0, 32'h0, 64'h0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 64'h0);
    check_main("after_rst", 64'h4, w(0), 64'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
